store_align_unit: RTL

Store-path companion to the load extension logic in the memory stage: takes a store request (address, rs2 data, funct3), rotates the data onto byte lanes and generates byte strobes. It issues word-aligned writes to the data-memory bus. Misaligned SH/SW accesses that cross a word boundary are split into two consecutive bus beats. It sits between the execute/memory pipeline register and the data-memory write port, with a valid/ready handshake on both sides.

---
 rtl/store_align_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/store_align_unit.sv
// Store alignment: rotates rs2 data onto byte lanes, builds byte strobes and
// issues one or two word-aligned write beats (two when the store crosses a word).
module store_align_lane #(
  parameter int LANES = 4,
  parameter int LANE  = 0
) (
  input  logic [LANES*8-1:0] data,
  input  logic [1:0]         off,
  output logic [7:0]         lane_byte
);
  logic [1:0] src;
  // 2-bit subtraction wraps, giving (LANE - off) mod 4
  assign src       = 2'(LANE) - off;
  assign lane_byte = data[src*8 +: 8];
endmodule

module store_align_unit #(
  parameter int REG_WIDTH_IN_BYTE = 4,
  parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE*8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_addr,
  input  logic [REG_WIDTH_IN_BIT-1:0]  req_data,
  input  logic [2:0]                   req_funct3,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [31:0]                  mem_addr,
  output logic [REG_WIDTH_IN_BIT-1:0]  mem_wdata,
  output logic [REG_WIDTH_IN_BYTE-1:0] mem_wstrb,
  output logic                         done,
  output logic                         err
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t state, state_nxt;
  logic   done_nxt, err_nxt;
  logic   legal, accept, split;
  logic [REG_WIDTH_IN_BYTE-1:0][7:0]   rot;
  logic [2*REG_WIDTH_IN_BYTE-1:0]      base_mask, mask8;
  logic [REG_WIDTH_IN_BYTE-1:0]        strb_hi;

  for (genvar i = 0; i < REG_WIDTH_IN_BYTE; i++) begin : g_lane
    store_align_lane #(.LANES(REG_WIDTH_IN_BYTE), .LANE(i)) u_lane (
      .data      (req_data),
      .off       (req_addr[1:0]),
      .lane_byte (rot[i])
    );
  end

  always_comb begin
    base_mask = '0;
    case (req_funct3)
      3'b000:  base_mask = 8'b0000_0001;
      3'b001:  base_mask = 8'b0000_0011;
      3'b010:  base_mask = 8'b0000_1111;
      default: base_mask = '0;
    endcase
  end

  assign mask8     = base_mask << req_addr[1:0];
  assign legal     = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
  assign req_ready = (state == IDLE);
  assign mem_valid = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign split     = |strb_hi;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE:
        if (req_valid) begin
          if (legal) state_nxt = BEAT0;
          else begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
          end
        end
      BEAT0:
        if (mem_ready) begin
          if (split) state_nxt = BEAT1;
          else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      BEAT1:
        if (mem_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  // Beat registers only move on accept or on the beat0->beat1 handoff, so they
  // stay put while the bus stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      strb_hi   <= '0;
    end else if (accept && legal) begin
      mem_addr  <= {req_addr[31:2], 2'b00};
      mem_wdata <= rot;
      mem_wstrb <= mask8[REG_WIDTH_IN_BYTE-1:0];
      strb_hi   <= mask8[2*REG_WIDTH_IN_BYTE-1:REG_WIDTH_IN_BYTE];
    end else if (state == BEAT0 && mem_ready && split) begin
      mem_addr  <= mem_addr + 32'd4;
      mem_wstrb <= strb_hi;
    end
  end
endmodule
